// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one fetch at a time, holds the result for decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        take_branch,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam logic [31:0] NopInst = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StTrap} state_e;
`else
    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold} state_e;
`endif

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [63:0] inst_pc_q, inst_pc_d;
    logic [63:0] redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc = branch_target;
`else
    assign redirect_pc = branch_target & ~64'h3;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        inst_out_d = inst_out_q;
        inst_pc_d  = inst_pc_q;

        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else begin
                        inst_out_d = imem_rdata;
                        inst_pc_d  = pc_q;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (inst_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = StReq;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            // A response accepted before the trap may still be in flight; swallow it here.
            StTrap: begin
                if (imem_rvalid) begin
                    discard_d = 1'b0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Redirect overrides every other event this cycle.
        if (take_branch) begin
            pc_d       = redirect_pc;
            inst_out_d = inst_out_q;
            inst_pc_d  = inst_pc_q;
            case (state_q)
                StReq: begin
                    if (imem_ready) begin
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state_d   = StReq;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                StTrap: begin
                    discard_d = discard_q & ~imem_rvalid;
                    state_d   = discard_d ? StWait : StReq;
                end
`endif
                default: state_d = StReq;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (branch_target[1:0] != 2'b00) begin
                state_d = StTrap;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            inst_out_q <= NopInst;
            inst_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            inst_out_q <= inst_out_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    assign imem_req   = (state_q == StReq);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == StHold) & ~take_branch;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misaligned = (state_q == StTrap);
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end of the sequential RV64 core.
- Owns the PC and issues 32-bit instruction fetches to instruction memory over a req/ready + rvalid interface.
- Presents fetched instructions to decode with a valid/ready handshake.
- Consumes the execute stage's take_branch/branch_target outputs to redirect the PC and squash stale or younger fetches.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- take_branch  input  1  execute-stage redirect request; single-cycle pulse.
- branch_target  input  64  redirect PC; valid when take_branch=1.
- imem_req  output  1  fetch request valid.
- imem_addr  output  64  fetch address (current PC).
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; exactly one per accepted request; earliest one cycle after acceptance.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_out  output  32  held instruction.
- inst_pc  output  64  PC of inst_out.
- inst_ready  input  1  decode accepts the instruction.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, discard=0.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_out=32'h0000_0013 (NOP), inst_pc=RESET_PC.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: imem_req=0; advances to REQ on the next edge. Occupies exactly one cycle after reset release.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready, go to WAIT. Otherwise stay in REQ.
  - WAIT: imem_req=0. On imem_rvalid with discard=0: latch imem_rdata into inst_out, latch pc into inst_pc, go to HOLD. On imem_rvalid with discard=1: clear discard, go to REQ, drop the data.
  - HOLD: inst_valid=1. On inst_valid&inst_ready: pc<=pc+4 (64-bit wrap), go to REQ.
- Throughput: best case one instruction per 3 cycles (REQ→WAIT→HOLD), assuming ready/rvalid arrive with no extra wait.
- Redirect (take_branch=1) has priority over every other event. In all cases pc<=branch_target on the same edge.
  - IDLE or REQ without imem_ready: next state is REQ. imem_addr may change while imem_req stays high; memory must sample the address only on ready.
  - REQ with imem_ready in the same cycle: the old address has been accepted. Go to WAIT with discard=1.
  - WAIT without imem_rvalid: stay in WAIT, set discard=1.
  - WAIT with imem_rvalid in the same cycle: drop the data, go to REQ, discard=0.
  - HOLD: inst_valid is gated combinationally (inst_valid = hold & ~take_branch). A same-cycle inst_ready is not a handshake and the held instruction is dropped. Go to REQ.
  - A redirect while discard=1: discard stays 1, because only one response is outstanding.
- Only one outstanding request at any time.
- Outputs driven from registered state, except the take_branch gating of inst_valid.
- Reset asserted mid-transaction returns to IDLE immediately. Any in-flight response is the memory's responsibility; imem_rvalid is ignored while in IDLE or REQ.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit) and state TRAP.
  - A redirect with branch_target[1:0]!=0 loads pc, enters TRAP, and drives fetch_misaligned=1, imem_req=0, inst_valid=0.
  - Only reset or another redirect with an aligned target leaves TRAP.
  - fetch_misaligned resets to 0.
- Undefined: branch_target[1:0] is forced to 2'b00 on load; no port or TRAP state exists.

Test Plan:
- Reset release, memory ready=1, rvalid one cycle later, decode ready=1 → imem_addr sequence 0x0, 0x4, 0x8. inst_valid one cycle in every 3. inst_pc matches the fetched address.
- Decode holds inst_ready=0 for 5 cycles during HOLD → inst_out/inst_pc stable, imem_req=0, pc unchanged. Next fetch is 0x4 after the handshake.
- take_branch pulse, target 0x100, in WAIT; stale rvalid returns 3 cycles later with 0xDEADBEEF → data never reaches inst_valid. Next imem_addr=0x100.
- take_branch in the same cycle as imem_ready at addr 0x8 → WAIT with discard set. First response dropped; next request address is the target.
- take_branch and inst_ready in the same HOLD cycle (inst_pc 0x10, target 0x200) → no handshake counted. Next imem_addr=0x200, not 0x14.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → fetch_misaligned=1, no requests. A subsequent redirect to 0x200 resumes fetching at 0x200. Without the macro: redirect to 0x102 fetches 0x100.
